wb_ctrl: RTL and testbench

Writeback controller that drives the register file write port (`RegWEn`, `rd`, `dataW`). Merges single-cycle ALU results with long-latency LSU results buffered in a 2-entry FIFO, and presents one registered write per cycle. Tracks in-flight long-latency destinations in a 32-bit busy scoreboard that issue logic queries for hazard stalls. Sits between the execute/LSU stages and the register file.

---
 rtl/wb_ctrl.sv | 112 +++++++++++
 tb/tb_wb_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_ctrl.sv
// rtl/wb_ctrl.sv - writeback merge of ALU and buffered LSU results, with long-op busy scoreboard
// Optional forwarding outputs are enabled by defining WB_FWD_EN.
module wb_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            issue_valid,
    input  logic            issue_long,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
`ifdef WB_FWD_EN
    output logic            fwd1_hit,
    output logic            fwd2_hit,
    output logic [XLEN-1:0] fwd1_data,
    output logic [XLEN-1:0] fwd2_data,
`endif
    output logic            RegWEn,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] dataW
);

    logic [4:0]      fifo_rd   [2];
    logic [XLEN-1:0] fifo_data [2];
    logic            wptr;
    logic            rptr;
    logic [1:0]      count;
    logic [31:0]     busy;
    logic [31:0]     busy_nxt;

    logic            push;
    logic            pop;
    logic            sel;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    // Ready is count-based: a full FIFO stays not-ready even when it pops this cycle.
    assign lsu_ready = (count < 2'd2) && rst;

    always_comb begin
        push     = lsu_valid && lsu_ready;
        pop      = !alu_valid && (count != 2'd0);
        sel      = alu_valid || (count != 2'd0);
        sel_rd   = alu_valid ? alu_rd   : fifo_rd[rptr];
        sel_data = alu_valid ? alu_data : fifo_data[rptr];

        busy_nxt = busy;
        if (pop) begin
            busy_nxt[fifo_rd[rptr]] = 1'b0;
        end
        // A re-issue to the register being retired keeps it busy.
        if (issue_valid && issue_long && (issue_rd != 5'd0)) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            count  <= 2'd0;
            busy   <= '0;
            RegWEn <= 1'b0;
            rd     <= '0;
            dataW  <= '0;
        end else begin
            if (push) begin
                fifo_rd[wptr]   <= lsu_rd;
                fifo_data[wptr] <= lsu_data;
                wptr            <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            busy   <= busy_nxt;
            RegWEn <= sel && (sel_rd != 5'd0);
            if (sel) begin
                rd    <= sel_rd;
                dataW <= sel_data;
            end
        end
    end

`ifdef WB_FWD_EN
    assign fwd1_hit  = RegWEn && (rd == rs1);
    assign fwd2_hit  = RegWEn && (rd == rs2);
    assign fwd1_data = dataW;
    assign fwd2_data = dataW;
    assign rs1_busy  = busy[rs1] && !fwd1_hit;
    assign rs2_busy  = busy[rs2] && !fwd2_hit;
`else
    assign rs1_busy  = busy[rs1];
    assign rs2_busy  = busy[rs2];
`endif

endmodule

// File: tb/tb_wb_ctrl.sv
// tb/tb_wb_ctrl.sv - scoreboard bench for wb_ctrl against a queue-based reference model
module tb_wb_ctrl;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            issue_valid;
    logic            issue_long;
    logic [4:0]      issue_rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rs1_busy;
    logic            rs2_busy;
`ifdef WB_FWD_EN
    logic            fwd1_hit;
    logic            fwd2_hit;
    logic [XLEN-1:0] fwd1_data;
    logic [XLEN-1:0] fwd2_data;
`endif
    logic            RegWEn;
    logic [4:0]      rd;
    logic [XLEN-1:0] dataW;

    always #5 clk = ~clk;

    wb_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef WB_FWD_EN
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
`endif
        .RegWEn(RegWEn), .rd(rd), .dataW(dataW)
    );

    typedef struct packed {
        logic            we;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wr_t;
    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    wr_t  exp_q[$];
    ent_t lq[$];
    bit   mbusy[32];
    logic            m_we;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_data;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called after inputs are driven at the negedge: checks combinational outputs,
    // then advances the model across the coming posedge and queues the expected write.
    task automatic step();
        bit   exp_rdy;
        bit   sel;
        ent_t w;
        bit   h1;
        bit   h2;
        #1;
        exp_rdy = rst && (lq.size() < 2);
        h1 = 1'b0;
        h2 = 1'b0;
`ifdef WB_FWD_EN
        h1 = m_we && (m_rd == rs1);
        h2 = m_we && (m_rd == rs2);
        check("fwd1_hit", fwd1_hit, h1);
        check("fwd2_hit", fwd2_hit, h2);
        if (h1) check("fwd1_data", fwd1_data, m_data);
        if (h2) check("fwd2_data", fwd2_data, m_data);
`endif
        check("lsu_ready", lsu_ready, exp_rdy);
        check("rs1_busy", rs1_busy, mbusy[rs1] && !h1);
        check("rs2_busy", rs2_busy, mbusy[rs2] && !h2);

        if (!rst) begin
            lq.delete();
            foreach (mbusy[i]) mbusy[i] = 1'b0;
            m_we = 1'b0; m_rd = '0; m_data = '0;
        end else begin
            sel = 1'b0;
            w   = '0;
            if (alu_valid) begin
                sel = 1'b1;
                w   = '{rd: alu_rd, data: alu_data};
            end else if (lq.size() > 0) begin
                sel = 1'b1;
                w   = lq.pop_front();
                mbusy[w.rd] = 1'b0;
            end
            if (lsu_valid && exp_rdy) lq.push_back('{rd: lsu_rd, data: lsu_data});
            if (issue_valid && issue_long && issue_rd != 0) mbusy[issue_rd] = 1'b1;
            if (sel) begin
                m_we = (w.rd != 0); m_rd = w.rd; m_data = w.data;
            end else begin
                m_we = 1'b0;
            end
        end
        exp_q.push_back('{we: m_we, rd: m_rd, data: m_data});
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        issue_valid = 0; issue_long = 0; issue_rd = 0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Monitor: the registered write port is compared once per edge against the oldest expectation.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("RegWEn", RegWEn, e.we);
                check("rd", rd, e.rd);
                check("dataW", dataW, e.data);
            end
        end
    end

    initial begin
        m_we = 0; m_rd = 0; m_data = 0;
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        rst = 0; rs1 = 0; rs2 = 0;
        idle();
        repeat (2) @(posedge clk);

        // Reset held two cycles with every valid high.
        repeat (2) begin
            cyc();
            alu_valid = 1; alu_rd = 5'd6; alu_data = 32'hA5A5A5A5;
            lsu_valid = 1; lsu_rd = 5'd8; lsu_data = 32'h5A5A5A5A;
            issue_valid = 1; issue_long = 1; issue_rd = 5'd9;
            rs1 = 5'd9; rs2 = 5'd6;
            step();
        end
        cyc(); rst = 1; idle(); step();

        // ALU write, then rd 0 variant.
        cyc(); alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; step();
        cyc(); alu_rd = 5'd0; alu_data = 32'h12345678; step();
        // ALU and LSU contend.
        cyc(); alu_rd = 5'd3; alu_data = 32'h11; lsu_valid = 1; lsu_rd = 5'd4; lsu_data = 32'h22; step();
        cyc(); idle(); step();
        cyc(); step();
        // Fill FIFO under continuous ALU traffic, then drain.
        for (int i = 0; i < 3; i++) begin
            cyc(); alu_valid = 1; alu_rd = 5'(10 + i); alu_data = 32'(100 + i);
            lsu_valid = 1; lsu_rd = 5'(20 + i); lsu_data = 32'(200 + i); step();
        end
        cyc(); idle(); step();
        repeat (3) begin cyc(); step(); end
        // Scoreboard: issue long rd 7, retire it while re-issuing rd 7.
        cyc(); issue_valid = 1; issue_long = 1; issue_rd = 5'd7; rs1 = 5'd7; step();
        cyc(); idle(); step();
        cyc(); lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'h55; rs2 = 5'd7; step();
        cyc(); idle(); issue_valid = 1; issue_long = 1; issue_rd = 5'd7; step();
        cyc(); idle(); step();
        cyc(); lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'h77; step();
        cyc(); idle(); step();
        cyc(); rs1 = 5'd9; rs2 = 5'd9; lsu_valid = 1; lsu_rd = 5'd9; lsu_data = 32'h55; step();
        cyc(); idle(); step();
        cyc(); step();

        // Randomized traffic with occasional mid-operation resets.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst         = ($urandom_range(0, 199) != 0);
            alu_valid   = ($urandom_range(0, 9) < 4);
            alu_rd      = 5'($urandom_range(0, 7));
            alu_data    = $urandom;
            lsu_valid   = $urandom_range(0, 1);
            lsu_rd      = 5'($urandom_range(0, 7));
            lsu_data    = $urandom;
            issue_valid = $urandom_range(0, 1);
            issue_long  = $urandom_range(0, 1);
            issue_rd    = 5'($urandom_range(0, 7));
            rs1         = 5'($urandom_range(0, 7));
            rs2         = 5'($urandom_range(0, 7));
            step();
        end
        cyc(); rst = 1; idle(); step();

        @(posedge clk);
        #2;
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
